// File: rtl/fetch_byte_queue_pkg.sv
// Shared constants for the fetch byte queue.
//   FQ_LINE_BYTES : bytes per incoming instruction line
//   FQ_BUF_BYTES  : capacity of the decode-facing window
//   fq_lane_msb() : MSB bit index of byte lane i in an MSB-first packed vector
package fetch_byte_queue_pkg;

   localparam int FQ_LINE_BYTES = 16;
   localparam int FQ_BUF_BYTES  = 32;

   // Byte 0 sits in the top lane; lane i occupies [msb -: 8].
   function automatic int fq_lane_msb(input int i, input int nbytes);
      return nbytes * 8 - 1 - 8 * i;
   endfunction

endpackage

// File: rtl/fetch_byte_funnel.sv
// Combinational shift-and-merge for the fetch queue. Element 0 is the MSB
// element of each packed vector. Used for the byte array (WIDTH=8) and the
// per-byte tag array (WIDTH=1).
//   cur    : current array (elements >= count are already zero)
//   rd     : elements retired from the front
//   pos    : insert position of the line (count - rd)
//   ld_en  : append the line this cycle
//   line   : incoming line elements, element 0 at MSB
//   offset : first valid line element; elements before it are dropped
//   nxt    : next array value
module fetch_byte_funnel
   import fetch_byte_queue_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = FQ_BUF_BYTES,
   parameter int L     = FQ_LINE_BYTES
) (
   input  logic [N*WIDTH-1:0] cur,
   input  logic [5:0]         rd,
   input  logic [5:0]         pos,
   input  logic               ld_en,
   input  logic [L*WIDTH-1:0] line,
   input  logic [3:0]         offset,
   output logic [N*WIDTH-1:0] nxt
);

   logic [N*WIDTH-1:0] shifted;
   logic [N*WIDTH-1:0] ins;
   logic [L*WIDTH-1:0] line_al;

   always_comb begin
      // Left shift fills vacated tail elements with zero.
      shifted = cur << (int'(rd) * WIDTH);
      // Dropping the leading offset elements leaves exactly L-offset valid
      // elements followed by zeros, so the OR below never disturbs anything
      // past the appended bytes.
      line_al = line << (int'(offset) * WIDTH);
      ins     = {line_al, {((N-L)*WIDTH){1'b0}}} >> (int'(pos) * WIDTH);
      nxt     = ld_en ? (shifted | ins) : shifted;
   end

endmodule

// File: rtl/fetch_byte_queue.sv
// Fetch-side byte queue feeding decode. Accepts 16-byte lines, holds up to
// 32 bytes, presents a left-aligned window with PC and byte count, and retires
// the bytes decode reports consumed.
//   clk, reset (async, active-low)
//   flush                    : drop all buffered bytes, refuse lines this cycle
//   l_valid/l_ready/l_data/l_offset/l_pc/l_branch_taken : line input
//   f_valid/f_ready/f_bytes_read                        : decode handshake
//   f_valid_bytes/f_instruction/f_pc/f_branch_taken     : window outputs
module fetch_byte_queue
   import fetch_byte_queue_pkg::*;
#(
   parameter int IADDRW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              l_valid,
   output logic              l_ready,
   input  logic [127:0]      l_data,
   input  logic [3:0]        l_offset,
   input  logic [IADDRW-1:0] l_pc,
   input  logic              l_branch_taken,
   output logic              f_valid,
   input  logic              f_ready,
   input  logic [5:0]        f_bytes_read,
   output logic [5:0]        f_valid_bytes,
   output logic [255:0]      f_instruction,
   output logic [IADDRW-1:0] f_pc,
   output logic              f_branch_taken
);

   logic [FQ_BUF_BYTES*8-1:0] buf_q, buf_d;
   logic [FQ_BUF_BYTES-1:0]   tag_q, tag_d;
   logic [5:0]                count;
   logic [IADDRW-1:0]         head_pc;

   logic [5:0] rd, rem, ld;
   logic       load;

   assign f_instruction  = buf_q;
   assign f_valid_bytes  = count;
   assign f_valid        = (count != 6'd0);
   assign f_pc           = head_pc;
   assign f_branch_taken = tag_q[FQ_BUF_BYTES-1];

   // Registered count only: space freed by this cycle's consume is not reused
   // until next cycle, which keeps rem <= 16 whenever a line is appended.
   assign l_ready = ~flush & (count <= 6'(FQ_LINE_BYTES));
   assign load    = l_valid & l_ready;
   assign ld      = 6'(FQ_LINE_BYTES) - {2'b00, l_offset};

   always_comb begin
      rd = 6'd0;
      if (f_valid && f_ready)
         rd = (f_bytes_read > count) ? count : f_bytes_read;
   end

   assign rem = count - rd;

   fetch_byte_funnel #(.WIDTH(8)) u_byte_funnel (
      .cur    (buf_q),
      .rd     (rd),
      .pos    (rem),
      .ld_en  (load),
      .line   (l_data),
      .offset (l_offset),
      .nxt    (buf_d)
   );

   fetch_byte_funnel #(.WIDTH(1)) u_tag_funnel (
      .cur    (tag_q),
      .rd     (rd),
      .pos    (rem),
      .ld_en  (load),
      .line   ({FQ_LINE_BYTES{l_branch_taken}}),
      .offset (l_offset),
      .nxt    (tag_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q   <= '0;
         tag_q   <= '0;
         count   <= 6'd0;
         head_pc <= '0;
      end else if (flush) begin
         // Bytes are zeroed too so the window never shows stale data.
         buf_q <= '0;
         tag_q <= '0;
         count <= 6'd0;
      end else begin
         buf_q   <= buf_d;
         tag_q   <= tag_d;
         count   <= rem + (load ? ld : 6'd0);
         // An emptied queue takes the PC of the line landing in it.
         head_pc <= (rem == 6'd0 && load) ? l_pc : head_pc + IADDRW'(rd);
      end
   end

endmodule
